// File: rtl/freq_sweep_ctrl.sv
// Stepped frequency sweep sequencer: drives a divider frequency word and enable with settle/dwell timing.
// Build option SWEEP_LOOP_EN: after each pass, restart from the latched start frequency until stopped.
module freq_sweep_ctrl #(
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned F_MAX      = 25_000_000,
  localparam int unsigned FW        = 28
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic [FW-1:0] i_freq_start,
  input  logic [FW-1:0] i_freq_stop,
  input  logic [FW-1:0] i_freq_step,
  input  logic [FW-1:0] i_dwell,
  output logic [FW-1:0] o_freq_num,
  output logic          o_sw,
  output logic          o_busy,
  output logic          o_step,
  output logic          o_done,
  output logic          o_err
);

  localparam logic [FW-1:0] SETTLE_LAST = FW'(SETTLE_CYC - 1);
  localparam logic [FW-1:0] FMAX_W      = FW'(F_MAX);

  typedef enum logic [2:0] {IDLE, SETTLE, DWELL, NEXT, DONE} state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] freq_q, freq_d;
  logic [FW-1:0] stop_q, stop_d;
  logic [FW-1:0] inc_q, inc_d;
  logic [FW-1:0] dwell_q, dwell_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          sw_q, sw_d;
  logic          busy_q, busy_d;
  logic          pulse_q, pulse_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef SWEEP_LOOP_EN
  logic [FW-1:0] start_q, start_d;
`endif

  logic [FW:0]   sum;
  logic [FW-1:0] dwell_last;
  logic          start_bad;

  // The sum keeps its carry so a step past the top of the 28-bit range ends the sweep instead of wrapping.
  assign sum        = {1'b0, freq_q} + {1'b0, inc_q};
  assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - FW'(1);
  assign start_bad  = (i_freq_start == '0) || (i_freq_step == '0) ||
                      (i_freq_start > i_freq_stop) || (i_freq_stop > FMAX_W);

  // Next-state and registered-output logic; i_stop outranks every other transition.
  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    stop_d  = stop_q;
    inc_d   = inc_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    busy_d  = busy_q;
    pulse_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef SWEEP_LOOP_EN
    start_d = start_q;
`endif
    if ((state_q != IDLE) && i_stop) begin
      state_d = IDLE;
      sw_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start && !i_stop) begin
            if (start_bad) begin
              err_d = 1'b1;
            end else begin
              state_d = SETTLE;
              freq_d  = i_freq_start;
              stop_d  = i_freq_stop;
              inc_d   = i_freq_step;
              dwell_d = i_dwell;
              cnt_d   = '0;
              sw_d    = 1'b0;
              busy_d  = 1'b1;
`ifdef SWEEP_LOOP_EN
              start_d = i_freq_start;
`endif
            end
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = DWELL;
            sw_d    = 1'b1;
            pulse_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + FW'(1);
          end
        end
        DWELL: begin
          if (cnt_q == dwell_last) begin
            state_d = NEXT;
            sw_d    = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + FW'(1);
          end
        end
        NEXT: begin
          if (sum > {1'b0, stop_q}) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SETTLE;
            freq_d  = sum[FW-1:0];
            cnt_d   = '0;
          end
        end
        DONE: begin
`ifdef SWEEP_LOOP_EN
          state_d = SETTLE;
          freq_d  = start_q;
          cnt_d   = '0;
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
        end
        default: begin
          state_d = IDLE;
          sw_d    = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      freq_q  <= '0;
      stop_q  <= '0;
      inc_q   <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      sw_q    <= 1'b0;
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SWEEP_LOOP_EN
      start_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      stop_q  <= stop_d;
      inc_q   <= inc_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      busy_q  <= busy_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SWEEP_LOOP_EN
      start_q <= start_d;
`endif
    end
  end

  assign o_freq_num = freq_q;
  assign o_sw       = sw_q;
  assign o_busy     = busy_q;
  assign o_step     = pulse_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed self-checking bench for freq_sweep_ctrl; a second instance with a widened F_MAX covers the 28-bit carry case.
module tb_freq_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_start, i_stop;
  logic [27:0] i_freq_start, i_freq_stop, i_freq_step, i_dwell;
  logic [27:0] d_freq, w_freq, m_freq;
  logic        d_sw, d_busy, d_step, d_done, d_err;
  logic        w_sw, w_busy, w_step, w_done, w_err;
  logic        m_sw, m_busy, m_step, m_done, m_err;
  bit          sel = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [27:0] step_freq[$];
  int          hi_len[$];
  int          lo_len[$];
  int          n_done, n_err, n_hi, n_busy, viol;
  logic [27:0] fst_freq;
  logic        fst_busy, fst_sw, fst_err;

  always #5 clk = ~clk;

  freq_sweep_ctrl u_dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_stop(i_stop),
    .i_freq_start(i_freq_start), .i_freq_stop(i_freq_stop),
    .i_freq_step(i_freq_step), .i_dwell(i_dwell),
    .o_freq_num(d_freq), .o_sw(d_sw), .o_busy(d_busy),
    .o_step(d_step), .o_done(d_done), .o_err(d_err)
  );

  freq_sweep_ctrl #(.F_MAX(32'h0FFF_FFFF)) u_wide (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_stop(i_stop),
    .i_freq_start(i_freq_start), .i_freq_stop(i_freq_stop),
    .i_freq_step(i_freq_step), .i_dwell(i_dwell),
    .o_freq_num(w_freq), .o_sw(w_sw), .o_busy(w_busy),
    .o_step(w_step), .o_done(w_done), .o_err(w_err)
  );

  assign m_freq = sel ? w_freq : d_freq;
  assign m_sw   = sel ? w_sw   : d_sw;
  assign m_busy = sel ? w_busy : d_busy;
  assign m_step = sel ? w_step : d_step;
  assign m_done = sel ? w_done : d_done;
  assign m_err  = sel ? w_err  : d_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sweep(input logic [27:0] fs, input logic [27:0] fe,
                           input logic [27:0] st, input logic [27:0] dw);
    i_freq_start = fs;
    i_freq_stop  = fe;
    i_freq_step  = st;
    i_dwell      = dw;
  endtask

  task automatic stop_all();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
  endtask

  // Step the selected instance, logging step frequencies, enable run lengths and rule violations.
  task automatic run(input int max_cyc, input bit expect_end);
    logic        prev_sw;
    logic [27:0] prev_f;
    int          lo, hi;
    bit          seen_busy, ended;
    step_freq.delete(); hi_len.delete(); lo_len.delete();
    n_done = 0; n_err = 0; n_hi = 0; n_busy = 0; viol = 0;
    prev_sw = m_sw; prev_f = m_freq; lo = 0; hi = 0; seen_busy = 0; ended = 0;
    for (int c = 0; c < max_cyc; c++) begin
      tick();
      i_start = 1'b0;
      if (c == 0) begin
        fst_freq = m_freq; fst_busy = m_busy; fst_sw = m_sw; fst_err = m_err;
      end
      if (m_done) n_done++;
      if (m_err)  n_err++;
      if (m_sw)   n_hi++;
      if (m_busy) n_busy++;
      if (m_sw && (m_freq == 28'd0)) viol++;
      if (m_sw && (m_freq != prev_f)) viol++;
      if (m_step) begin
        step_freq.push_back(m_freq);
        if (!(m_sw && !prev_sw)) viol++;
      end
      if (m_sw && !prev_sw) begin
        if (!m_step) viol++;
        lo_len.push_back(lo);
        lo = 0;
      end
      if (!m_sw && prev_sw) begin
        hi_len.push_back(hi);
        hi = 0;
      end
      if (m_sw) hi++;
      else if (m_busy) lo++;
      if (m_busy) seen_busy = 1'b1;
      prev_sw = m_sw;
      prev_f  = m_freq;
      if (seen_busy && !m_busy) begin
        ended = 1'b1;
        break;
      end
    end
    if (expect_end) check("sweep_end_in_budget", 32'(ended), 32'd1);
  endtask

  initial begin
    logic [27:0] e_fs[4];
    logic [27:0] e_fe[4];
    logic [27:0] e_st[4];
    int          exp_lo[3];
    bit          found;
    e_fs = '{28'd0,    28'd1000, 28'd5000, 28'd1000};
    e_fe = '{28'd3000, 28'd3000, 28'd4000, 28'd30_000_000};
    e_st = '{28'd1000, 28'd0,    28'd1000, 28'd1000};
    exp_lo = '{16, 17, 17};

    rstn = 1'b0; i_start = 1'b0; i_stop = 1'b0;
    set_sweep(28'd0, 28'd0, 28'd0, 28'd0);
    #1;
    check("rst_freq", 32'(d_freq), 32'd0);
    check("rst_flags", 32'({d_sw, d_busy, d_step, d_done, d_err}), 32'd0);
    tick(); tick();
    rstn = 1'b1;
    tick();

`ifndef SWEEP_LOOP_EN
    // Basic three-frequency sweep.
    set_sweep(28'd1000, 28'd3000, 28'd1000, 28'd5);
    i_start = 1'b1;
    run(400, 1'b1);
    check("t1_first_freq", 32'(fst_freq), 32'd1000);
    check("t1_first_busy", 32'(fst_busy), 32'd1);
    check("t1_first_sw",   32'(fst_sw),   32'd0);
    check("t1_nsteps", 32'(step_freq.size()), 32'd3);
    for (int i = 0; i < step_freq.size(); i++)
      check($sformatf("t1_freq%0d", i), 32'(step_freq[i]), 32'(1000 * (i + 1)));
    check("t1_nhi", 32'(hi_len.size()), 32'd3);
    for (int i = 0; i < hi_len.size(); i++)
      check($sformatf("t1_hi%0d", i), 32'(hi_len[i]), 32'd5);
    for (int i = 0; i < lo_len.size() && i < 3; i++)
      check($sformatf("t1_lo%0d", i), 32'(lo_len[i]), 32'(exp_lo[i]));
    check("t1_done", 32'(n_done), 32'd1);
    check("t1_viol", 32'(viol), 32'd0);
    check("t1_last_freq", 32'(d_freq), 32'd3000);
    check("t1_end_sw", 32'(d_sw), 32'd0);
`endif

    // Rejected starts.
    for (int k = 0; k < 4; k++) begin
      set_sweep(e_fs[k], e_fe[k], e_st[k], 28'd5);
      i_start = 1'b1;
      run(20, 1'b0);
      check($sformatf("t2_err_first%0d", k), 32'(fst_err), 32'd1);
      check($sformatf("t2_err_cnt%0d", k), 32'(n_err), 32'd1);
      check($sformatf("t2_busy%0d", k), 32'(n_busy), 32'd0);
      check($sformatf("t2_sw%0d", k), 32'(n_hi), 32'd0);
    end
    stop_all();

    // Start together with stop in IDLE: stop wins.
    set_sweep(28'd1000, 28'd3000, 28'd1000, 28'd5);
    i_start = 1'b1; i_stop = 1'b1;
    tick();
    i_start = 1'b0; i_stop = 1'b0;
    check("t3_busy", 32'(d_busy), 32'd0);
    check("t3_err",  32'(d_err),  32'd0);
    run(30, 1'b0);
    check("t3_stay_idle", 32'(n_busy), 32'd0);

    // Stop on the third dwell cycle of the second frequency.
    set_sweep(28'd1000, 28'd3000, 28'd1000, 28'd5);
    i_start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      i_start = 1'b0;
      if (d_step && (d_freq == 28'd2000)) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_reach_f2", 32'(found), 32'd1);
    tick(); tick();
    check("t4_dwell3_sw", 32'(d_sw), 32'd1);
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    check("t4_sw",   32'(d_sw),   32'd0);
    check("t4_busy", 32'(d_busy), 32'd0);
    check("t4_done", 32'(d_done), 32'd0);
    run(40, 1'b0);
    check("t4_no_done", 32'(n_done), 32'd0);
    check("t4_no_busy", 32'(n_busy), 32'd0);

`ifndef SWEEP_LOOP_EN
    // Carry out of 28 bits ends the sweep after one frequency.
    sel = 1'b1;
    set_sweep(28'h0FF_FFF0, 28'h0FF_FFFF, 28'h20, 28'd3);
    set_sweep(28'h0FFF_FFF0, 28'h0FFF_FFFF, 28'h20, 28'd3);
    i_start = 1'b1;
    run(200, 1'b1);
    check("t5_nsteps", 32'(step_freq.size()), 32'd1);
    if (step_freq.size() > 0) check("t5_freq", 32'(step_freq[0]), 32'h0FFF_FFF0);
    check("t5_done", 32'(n_done), 32'd1);
    check("t5_last_freq", 32'(w_freq), 32'h0FFF_FFF0);
    sel = 1'b0;

    // Zero dwell behaves as one cycle; start equal to stop.
    set_sweep(28'd500, 28'd500, 28'd1, 28'd0);
    i_start = 1'b1;
    run(100, 1'b1);
    check("t6_nsteps", 32'(step_freq.size()), 32'd1);
    if (hi_len.size() > 0) check("t6_hi", 32'(hi_len[0]), 32'd1);
    check("t6_done", 32'(n_done), 32'd1);
`endif

    // Reset asserted mid-settle, then a fresh start.
    set_sweep(28'd1000, 28'd3000, 28'd1000, 28'd5);
    i_start = 1'b1;
    run(5, 1'b0);
    check("t7_pre_busy", 32'(d_busy), 32'd1);
    rstn = 1'b0;
    #1;
    check("t7_rst_freq", 32'(d_freq), 32'd0);
    check("t7_rst_flags", 32'({d_sw, d_busy, d_step, d_done, d_err}), 32'd0);
    tick();
    rstn = 1'b1;
    run(30, 1'b0);
    check("t7_no_resume", 32'(n_busy), 32'd0);
    check("t7_no_done", 32'(n_done), 32'd0);
    i_start = 1'b1;
`ifndef SWEEP_LOOP_EN
    run(400, 1'b1);
    check("t7_nsteps", 32'(step_freq.size()), 32'd3);
`else
    run(40, 1'b0);
    stop_all();
`endif
    check("t7_restart_freq", 32'(fst_freq), 32'd1000);
    check("t7_restart_busy", 32'(fst_busy), 32'd1);

`ifdef SWEEP_LOOP_EN
    // Looping sweep: 1000, 2000, 1000, 2000 with a done pulse after each 2000.
    begin
      logic [27:0] lf[$];
      int          done_at[$];
      int          drops;
      drops = 0;
      set_sweep(28'd1000, 28'd2000, 28'd1000, 28'd2);
      i_start = 1'b1;
      for (int c = 0; c < 500; c++) begin
        tick();
        i_start = 1'b0;
        if (d_step) lf.push_back(d_freq);
        if (!d_busy) drops++;
        if (d_done) done_at.push_back(lf.size());
        if (done_at.size() == 2) break;
      end
      check("t8_ndone", 32'(done_at.size()), 32'd2);
      check("t8_nsteps", 32'(lf.size()), 32'd4);
      for (int i = 0; i < lf.size() && i < 4; i++)
        check($sformatf("t8_freq%0d", i), 32'(lf[i]), 32'((i % 2 == 0) ? 1000 : 2000));
      for (int i = 0; i < done_at.size(); i++)
        check($sformatf("t8_done_after%0d", i), 32'(done_at[i]), 32'(2 * (i + 1)));
      check("t8_busy_held", 32'(drops), 32'd0);
      stop_all();
      check("t8_stop_busy", 32'(d_busy), 32'd0);
      check("t8_stop_sw", 32'(d_sw), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_sweep_ctrl.md
FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 16, number of cycles o_sw is held low after each frequency change.
REQ-002 SHALL have parameter F_MAX, default 25_000_000, highest legal frequency in Hz.
REQ-003 SHALL have port clk, input, 1, the single system clock (100 MHz).
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_start, input, 1, single-cycle request to begin a sweep.
REQ-006 SHALL have port i_stop, input, 1, abort request.
REQ-007 SHALL have port i_freq_start, input, 28, first frequency in Hz.
REQ-008 SHALL have port i_freq_stop, input, 28, last frequency limit in Hz.
REQ-009 SHALL have port i_freq_step, input, 28, frequency increment in Hz.
REQ-010 SHALL have port i_dwell, input, 28, on-time per frequency in clk cycles.
REQ-011 SHALL have port o_freq_num, output, 28, frequency word to the clock divider.
REQ-012 SHALL have port o_sw, output, 1, divider enable.
REQ-013 SHALL have port o_busy, output, 1, high while any sweep is in progress.
REQ-014 SHALL have port o_step, output, 1, one-cycle pulse on each o_sw rising edge.
REQ-015 SHALL have port o_done, output, 1, one-cycle pulse at normal sweep end.
REQ-016 SHALL have port o_err, output, 1, one-cycle pulse when a start request is rejected.

Function
REQ-017 SHALL implement the states IDLE, SETTLE, DWELL, NEXT and DONE.
REQ-018 SHALL sample i_start in IDLE only and ignore it in all other states.
REQ-019 SHALL latch i_freq_stop, i_freq_step and i_dwell on an accepted start and hold them constant for the whole sweep.
REQ-020 SHALL reject a start, pulse o_err for one cycle and stay in IDLE when any of these holds: start frequency = 0, step = 0, start frequency > stop frequency, or stop frequency > F_MAX.
REQ-021 SHALL, on an accepted start, set o_freq_num = i_freq_start, keep o_sw = 0, raise o_busy and move to SETTLE, all registered one cycle after i_start.
REQ-022 SHALL stay in SETTLE for exactly SETTLE_CYC cycles with o_sw = 0 and then move to DWELL.
REQ-023 SHALL drive o_sw = 1 throughout DWELL, pulse o_step in the first DWELL cycle, and remain in DWELL for max(i_dwell, 1) cycles.
REQ-024 SHALL, in NEXT, compute o_freq_num + step as a 29-bit sum; if the sum exceeds the stop frequency, go to DONE; otherwise load the sum into o_freq_num, drive o_sw = 0 and go to SETTLE.
REQ-025 SHALL, in DONE, pulse o_done for one cycle, drive o_sw = 0, clear o_busy and return to IDLE, with o_freq_num holding the last value.
REQ-026 SHALL, on i_stop in any non-IDLE state, go to IDLE on the next cycle with o_sw = 0, o_busy = 0 and no o_done pulse; i_stop takes priority over every other transition.
REQ-027 SHALL, when i_start and i_stop are asserted together in IDLE, let i_stop win and ignore the start.
REQ-028 SHALL never drive o_sw = 1 while o_freq_num = 0.
REQ-029 SHALL drive o_sw = 0 in the cycle where o_freq_num changes, so the divider counters clear before the next enable.
REQ-030 SHALL register all outputs.

Reset
REQ-031 SHALL, while rstn = 0, immediately force the state to IDLE, o_freq_num = 0, and o_sw, o_busy, o_step, o_done and o_err all to 0.
REQ-032 SHALL, on rstn assertion mid-sweep, abandon the sweep with no o_done pulse, and after release SHALL require a new i_start.

Configuration
REQ-033 SHALL, when macro SWEEP_LOOP_EN is defined, go from DONE back to SETTLE with o_freq_num reloaded to the latched start frequency (o_busy stays 1; o_done still pulses each pass) until i_stop is asserted.
REQ-034 SHALL, when SWEEP_LOOP_EN is undefined, return from DONE to IDLE after a single pass.

Verification
REQ-035 SHALL cover: start=1000, stop=3000, step=1000, dwell=5 -> o_freq_num takes 1000, 2000, 3000; three o_step pulses; o_sw high for 5 cycles each time, preceded by 16 low cycles; then one o_done pulse.
REQ-036 SHALL cover: start=0 or step=0 or start=5000 with stop=4000 or stop=30_000_000 -> one o_err pulse, o_busy stays 0, o_sw stays 0.
REQ-037 SHALL cover: i_stop pulsed on DWELL cycle 3 of the second frequency -> o_sw = 0 and o_busy = 0 on the next cycle, no o_done pulse.
REQ-038 SHALL cover: start=0x0FFFFFF0, stop=0x0FFFFFFF, step=0x20 -> exactly one frequency visited; the 29-bit sum exceeds stop, so the sweep ends with o_done and o_freq_num does not wrap.
REQ-039 SHALL cover: rstn pulsed low mid-SETTLE -> all outputs 0 immediately; a later i_start restarts the sweep from i_freq_start.
REQ-040 SHALL cover, with SWEEP_LOOP_EN defined: start=1000, stop=2000, step=1000 -> sequence 1000, 2000, 1000, 2000 with an o_done pulse after each 2000, until i_stop.
